// File: rtl/rr_arbiter4.sv
// rr_arbiter4 - four-requester round-robin arbiter with a bounded hold time.
//
// An owner keeps the grant for as long as it holds its request line. Once it
// has held the grant for MAX_HOLD cycles and some other requester is waiting,
// the grant is revoked and a one-cycle preempt pulse is raised. Every change of
// owner passes through one IDLE cycle, so two grants never overlap.
//
// Handshake: req[i] is a level request. Requester i owns the resource on every
// cycle where gnt[i]=1. It keeps req[i] high while it still wants the resource
// and lowers it to release. Dropping req[i] at cycle t clears gnt at t+1.
//
// Parameters:
//   MAX_HOLD   grant cycles allowed per ownership under contention (1..255)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[3:0]   request lines, one per requester
//   gnt[3:0]   one-hot grant, or all zero (registered)
//   gnt_id     index of the current owner, or of the last one (registered)
//   gnt_valid  high while gnt is non-zero (registered)
//   preempt    one-cycle pulse when the hold limit revokes a grant (registered)
//   dbg_state  current FSM state (0 = IDLE, 1 = GRANT), for checkers

module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt,
  output logic       dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic       r_preempt, w_preempt_nxt;

  // Round-robin winner. Rotate req so that bit ptr lands at position 0, take
  // the lowest set bit, then add ptr back. The 2-bit sum wraps modulo 4.
  logic [7:0] w_req_dbl;
  logic [7:0] w_req_shift;
  logic [3:0] w_req_rot;
  logic [1:0] w_off;
  logic [1:0] w_win;

  assign w_req_dbl   = {req, req};
  assign w_req_shift = w_req_dbl >> r_ptr;
  assign w_req_rot   = w_req_shift[3:0];

  always_comb begin
    w_off = 2'd0;
    if      (w_req_rot[0]) w_off = 2'd0;
    else if (w_req_rot[1]) w_off = 2'd1;
    else if (w_req_rot[2]) w_off = 2'd2;
    else if (w_req_rot[3]) w_off = 2'd3;
  end

  assign w_win = r_ptr + w_off;

  logic w_owner_req;
  logic w_contend;
  logic w_hold_expired;

  assign w_owner_req    = req[r_owner];
  assign w_contend      = |(req & ~r_gnt);
  assign w_hold_expired = (r_hold >= HOLD_LIM);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_owner_nxt   = r_owner;
    w_gnt_nxt     = r_gnt;
    w_preempt_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_win;
          w_gnt_nxt   = 4'b0001 << w_win;
          w_hold_nxt  = 8'd1;
        end
      end
      ST_GRANT: begin
        // Release is checked first, so it wins over preempt in the same cycle.
        if (!w_owner_req || (w_hold_expired && w_contend)) begin
          w_state_nxt   = ST_IDLE;
          w_gnt_nxt     = 4'b0000;
          w_ptr_nxt     = r_owner + 2'd1;
          w_preempt_nxt = w_owner_req;
        end else if (r_hold != 8'hFF) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 2'd0;
      r_hold    <= 8'd0;
      r_owner   <= 2'd0;
      r_gnt     <= 4'b0000;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_owner   <= w_owner_nxt;
      r_gnt     <= w_gnt_nxt;
      r_preempt <= w_preempt_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_owner;
  assign gnt_valid = (r_state == ST_GRANT);
  assign preempt   = r_preempt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4 - directed bench for rr_arbiter4 with MAX_HOLD=4.
// A table of single-cycle vectors is applied first. It is followed by
// hand-written sequences for full-contention rotation and a long uncontended
// hold.

module tb_rr_arbiter4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;
  logic       dbg_state;

  int n_tests;
  int n_fail;

  rr_arbiter4 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       valid;
    logic       pre;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];

  // Scoreboard. Each expected output bundle is pushed as {gnt,id,valid,pre}.
  logic [7:0] exp_q[$];

  task automatic check(input string name);
    logic [7:0] exp;
    logic [7:0] act;
    exp = exp_q.pop_front();
    act = {gnt, gnt_id, gnt_valid, preempt};
    n_tests++;
    if (act !== exp || dbg_state !== gnt_valid) begin
      n_fail++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b pre=%b state=%b, want gnt=%b id=%0d valid=%b pre=%b",
               name, gnt, gnt_id, gnt_valid, preempt, dbg_state,
               exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  // driver: inputs change on the falling edge, outputs are sampled 1ns after the rising edge
  task automatic step(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [3:0] g, input logic [1:0] id,
                            input logic v, input logic p);
    exp_q.push_back({g, id, v, p});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    req = 4'b0000;

    //           rst   req      gnt      id     valid pre
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0}; // basic grant
    vecs[2]  = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // release, ptr=1
    vecs[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0}; // release, ptr=3
    vecs[8]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0}; // scan 3,0 -> 0
    vecs[9]  = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0}; // 4th cycle held
    vecs[12] = '{1'b0, 4'b0011, 4'b0000, 2'd0, 1'b0, 1'b1}; // preempt
    vecs[13] = '{1'b0, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0}; // owner 1
    vecs[14] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'b0110, 4'b0010, 2'd1, 1'b1, 1'b0}; // hold hits 4
    vecs[17] = '{1'b0, 4'b0100, 4'b0000, 2'd1, 1'b0, 1'b0}; // release beats preempt
    vecs[18] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 4'b1000, 4'b0000, 2'd2, 1'b0, 1'b0}; // ptr=3
    vecs[20] = '{1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 4'b1010, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[22] = '{1'b1, 4'b1010, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset mid-grant
    vecs[23] = '{1'b0, 4'b1010, 4'b0010, 2'd1, 1'b1, 1'b0}; // ptr=0 -> 1 wins
    vecs[24] = '{1'b0, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};

    for (int i = 0; i < NVEC; i++) begin
      expect_out(vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].pre);
      step(vecs[i].rst, vecs[i].req);
      check($sformatf("vec%0d", i));
    end

    // Full contention: owners 0,1,2,3,0, each for 4 cycles, then one preempt gap.
    expect_out(4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0000);
    check("rot_reset");
    for (int k = 0; k < 5; k++) begin
      logic [1:0] o;
      o = 2'(k % 4);
      for (int c = 0; c < 4; c++) begin
        expect_out(4'b0001 << o, o, 1'b1, 1'b0);
        step(1'b0, 4'b1111);
        check($sformatf("rot_own%0d_c%0d", k, c));
      end
      expect_out(4'b0000, o, 1'b0, 1'b1);
      step(1'b0, 4'b1111);
      check($sformatf("rot_gap%0d", k));
    end

    // A single requester is never preempted and its hold count saturates cleanly.
    expect_out(4'b0000, 2'd0, 1'b0, 1'b0);
    step(1'b1, 4'b0000);
    check("hold_reset");
    for (int c = 0; c < 300; c++) begin
      expect_out(4'b1000, 2'd3, 1'b1, 1'b0);
      step(1'b0, 4'b1000);
      check($sformatf("hold_c%0d", c));
    end
    expect_out(4'b0000, 2'd3, 1'b0, 1'b0);
    step(1'b0, 4'b0000);
    check("hold_release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
